// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared widths, MMIO address and phase encoding for the LC-3 memory responder.
package mem_io_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int SRAM_AW = 20;
    localparam logic [15:0] IO_ADDR = 16'hFFFF;
    typedef enum logic [1:0] {IDLE, P2, P3, HOLD} phase_t;
endpackage

// File: rtl/mem_io_if.sv
// mem_io_if: CPU-side MIO_EN/R_W bus between MAR/MDR and the memory responder.
interface mem_io_if #(
    parameter int ADDR_W = mem_io_pkg::ADDR_W,
    parameter int DATA_W = mem_io_pkg::DATA_W
);
    logic              MIO_EN;
    logic              R_W;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_from_CPU;
    logic [DATA_W-1:0] Data_to_CPU;
    logic              Ready;
    logic              Err;
    modport master (output MIO_EN, R_W, ADDR, Data_from_CPU, input Data_to_CPU, Ready, Err);
    modport slave (input MIO_EN, R_W, ADDR, Data_from_CPU, output Data_to_CPU, Ready, Err);
endinterface

// File: rtl/mem_io_mmio.sv
// mem_io_mmio: switch/SRAM read-data mux and the hex display register at the MMIO address.
module mem_io_mmio #(
    parameter int DATA_W = mem_io_pkg::DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              sel,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] Switches,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] Hex_Data
);
    assign rd_data = sel ? Switches : sram_rdata;

    always_ff @(posedge Clk) begin
        if (Reset)
            Hex_Data <= '0;
        else if (sel && we)
            Hex_Data <= wdata;
    end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: three-cycle SRAM/MMIO responder for the LC-3 MIO_EN/R_W bus.
module mem_io_responder #(
    parameter int               ADDR_W  = mem_io_pkg::ADDR_W,
    parameter int               DATA_W  = mem_io_pkg::DATA_W,
    parameter int               SRAM_AW = mem_io_pkg::SRAM_AW,
    parameter logic [ADDR_W-1:0] IO_ADDR = mem_io_pkg::IO_ADDR
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_io_if.slave            bus,
    input  logic [DATA_W-1:0]  Switches,
    output logic [DATA_W-1:0]  Hex_Data,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    input  logic [DATA_W-1:0]  SRAM_DQ_in,
    output logic [DATA_W-1:0]  SRAM_DQ_out,
    output logic               SRAM_DQ_oe
);
    import mem_io_pkg::*;

    phase_t            state, state_d;
    logic              armed, err_d, en, is_io, p1, p2, p3, active;
    logic [DATA_W-1:0] rd_data;

    assign en     = bus.MIO_EN;
    assign is_io  = bus.ADDR == IO_ADDR;
    assign p1     = state == IDLE && armed && en;
    assign p2     = state == P2 && en;
    assign p3     = state == P3 && en;
    assign active = (p1 || p2 || p3) && !is_io;

    // MIO_EN still high right after P3 lands in unarmed IDLE; that is the overlong case.
    always_comb begin
        state_d = state;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                state_d = en ? (armed ? P2 : HOLD) : IDLE;
                err_d   = en && !armed;
            end
            P2: begin
                state_d = en ? P3 : IDLE;
                err_d   = !en;
            end
            P3: begin
                state_d = IDLE;
                err_d   = !en;
            end
            HOLD:    state_d = en ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= IDLE;
            armed           <= 1'b1;
            bus.Err         <= 1'b0;
            bus.Data_to_CPU <= '0;
        end else begin
            state   <= state_d;
            armed   <= !en || (armed && !p1);
            bus.Err <= err_d;
            if (p2 && !bus.R_W)
                bus.Data_to_CPU <= rd_data;
        end
    end

    mem_io_mmio #(.DATA_W(DATA_W)) u_mmio (
        .Clk        (Clk),
        .Reset      (Reset),
        .sel        (is_io),
        .we         (p2 && bus.R_W),
        .wdata      (bus.Data_from_CPU),
        .Switches   (Switches),
        .sram_rdata (SRAM_DQ_in),
        .rd_data    (rd_data),
        .Hex_Data   (Hex_Data)
    );

    assign bus.Ready   = p3;
    assign SRAM_ADDR   = SRAM_AW'(bus.ADDR);
    assign SRAM_CE_N   = !active;
    assign SRAM_UB_N   = !active;
    assign SRAM_LB_N   = !active;
    assign SRAM_OE_N   = !(active && !bus.R_W);
    assign SRAM_WE_N   = !(p2 && !is_io && bus.R_W);
    assign SRAM_DQ_oe  = active && bus.R_W;
    assign SRAM_DQ_out = bus.Data_from_CPU;
endmodule
